cordic_arbiter: RTL and testbench

CORDIC_ARBITER -- requirements
Module: cordic_arbiter

---
 rtl/cordic_pkg.sv | 23 ++
 rtl/cordic_arbiter_rr_pick.sv | 31 +++
 rtl/cordic_arbiter.sv | 144 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request arbiter: default widths,
// the controller state encoding and Q2.14 constants.
package cordic_pkg;

    localparam int W_DEFAULT   = 16;
    localparam int TMO_DEFAULT = 31;

    // Q2.14 representation of 1.0
    localparam logic [15:0] Q14_ONE = 16'h4000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    // Width needed to index n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cordic_arbiter_rr_pick.sv
// Round-robin pick: the first requester found when scanning upward from
// the one after ptr, wrapping modulo N. Purely combinational.
module rr_pick
    import cordic_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // Scan the N candidates in priority order and keep the first hit.
    always_comb begin
        logic [IW-1:0] cand;
        logic          hit;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand  = IW'((int'(ptr) + 1 + k) % N);
            hit   = !valid && req[cand];
            idx   = hit ? cand : idx;
            valid = valid | req[cand];
        end
    end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one CORDIC datapath among N requesters. One job runs at a time:
// grant (round-robin), pulse dp_bgn, wait for dp_fin or time out, then
// return a one-cycle ack with the result (or err) to the granted requester.
module cordic_arbiter
    import cordic_pkg::*;
#(
    parameter int N   = 4,
    parameter int W   = W_DEFAULT,
    parameter int TMO = TMO_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] theta_in,
    output logic [N-1:0]   ack,
    output logic           err,
    output logic [W-1:0]   cos_out,
    output logic           busy,
    output logic           dp_bgn,
    output logic [W-1:0]   dp_theta,
    input  logic           dp_fin,
    input  logic [W-1:0]   dp_cos
);

    localparam int IW = idx_width(N);
    localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [CW:0]   TMO_L   = (CW + 1)'(TMO);
    localparam logic [IW-1:0] PTR_RST = IW'(N - 1);

    state_t        state_r;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] gidx_r;
    logic [CW-1:0] tmo_cnt_r;
    logic [W-1:0]  dp_theta_r;
    logic [W-1:0]  result_r;
    logic          err_flag_r;
    logic [N-1:0]  ack_r;
    logic          busy_r;
    logic          dp_bgn_r;

    logic          pick_valid_s;
    logic [IW-1:0] pick_idx_s;
    logic [W-1:0]  theta_sel_s;
    logic [N-1:0]  gidx_onehot_s;
    logic [CW:0]   tmo_nxt_s;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign theta_sel_s   = theta_in[int'(pick_idx_s) * W +: W];
    assign gidx_onehot_s = {{(N - 1){1'b0}}, 1'b1} << gidx_r;
    // The counter value this RUN cycle would advance to; reaching TMO
    // here makes the response land TMO+1 cycles after LOAD.
    assign tmo_nxt_s     = {1'b0, tmo_cnt_r} + {{CW{1'b0}}, 1'b1};

    // Controller: grant, launch, wait/timeout, respond. All outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= PTR_RST;
            gidx_r     <= '0;
            tmo_cnt_r  <= '0;
            dp_theta_r <= '0;
            result_r   <= '0;
            err_flag_r <= 1'b0;
            ack_r      <= '0;
            busy_r     <= 1'b0;
            dp_bgn_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    ack_r      <= '0;
                    result_r   <= '0;
                    err_flag_r <= 1'b0;
                    if (pick_valid_s) begin
                        gidx_r     <= pick_idx_s;
                        ptr_r      <= pick_idx_s;
                        dp_theta_r <= theta_sel_s;
                        dp_bgn_r   <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= LOAD;
                    end else begin
                        dp_bgn_r   <= 1'b0;
                        busy_r     <= 1'b0;
                        state_r    <= IDLE;
                    end
                end
                LOAD: begin
                    dp_bgn_r  <= 1'b0;
                    tmo_cnt_r <= '0;
                    state_r   <= RUN;
                end
                RUN: begin
                    // A finishing datapath takes precedence over a timeout
                    // expiring in the same cycle.
                    if (dp_fin) begin
                        result_r   <= dp_cos;
                        err_flag_r <= 1'b0;
                        ack_r      <= gidx_onehot_s;
                        state_r    <= RESP;
                    end else if (tmo_nxt_s == TMO_L) begin
                        result_r   <= '0;
                        err_flag_r <= 1'b1;
                        ack_r      <= gidx_onehot_s;
                        state_r    <= RESP;
                    end else begin
                        tmo_cnt_r  <= tmo_nxt_s[CW-1:0];
                        state_r    <= RUN;
                    end
                end
                RESP: begin
                    ack_r      <= '0;
                    result_r   <= '0;
                    err_flag_r <= 1'b0;
                    busy_r     <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    ack_r      <= '0;
                    result_r   <= '0;
                    err_flag_r <= 1'b0;
                    busy_r     <= 1'b0;
                    dp_bgn_r   <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_r;
    assign err      = err_flag_r;
    assign cos_out  = result_r;
    assign busy     = busy_r;
    assign dp_bgn   = dp_bgn_r;
    assign dp_theta = dp_theta_r;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: a datapath stand-in with programmable latency,
// a job-level model predicting every output each cycle, and directed tests.
module tb_cordic_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 31;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] theta_in = '0;
    logic [N-1:0]   ack;
    logic           err;
    logic [W-1:0]   cos_out;
    logic           busy;
    logic           dp_bgn;
    logic [W-1:0]   dp_theta;
    logic           dp_fin = 1'b0;
    logic [W-1:0]   dp_cos = '0;

    cordic_arbiter #(.N(N), .W(W), .TMO(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .theta_in (theta_in),
        .ack      (ack),
        .err      (err),
        .cos_out  (cos_out),
        .busy     (busy),
        .dp_bgn   (dp_bgn),
        .dp_theta (dp_theta),
        .dp_fin   (dp_fin),
        .dp_cos   (dp_cos)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    int cyc = 0;
    // Cycle counter: value during cycle c is c
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Datapath stand-in configuration
    int          dp_lat    = 5;
    bit          dp_never  = 1'b0;
    logic [W-1:0] dp_ret   = '0;
    int          stray_cyc = -1;
    int          last_bgn  = -1;
    int          n_bgn     = 0;
    int          fin_cyc   = -1;
    bit          pend      = 1'b0;

    // Datapath stand-in: dp_fin exactly dp_lat cycles after the dp_bgn cycle
    always begin
        @(posedge clk);
        #2;
        dp_fin = 1'b0;
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (pend && cyc == fin_cyc) begin
                dp_fin = 1'b1;
                dp_cos = dp_ret;
                pend   = 1'b0;
            end
            if (dp_bgn) begin
                last_bgn = cyc;
                n_bgn++;
                if (!dp_never) begin
                    pend    = 1'b1;
                    fin_cyc = cyc + dp_lat;
                end
            end
        end
        if (cyc == stray_cyc) begin
            dp_fin = 1'b1;
            dp_cos = 16'hBEEF;
        end
    end

    // Job-level model: one job at a time, described by its grant index,
    // launch cycle and response cycle derived from the datapath latency.
    bit           m_job   = 1'b0;
    int           m_load  = 0;
    int           m_resp  = 0;
    int           m_last  = N - 1;
    int           m_gidx  = 0;
    bit           m_err   = 1'b0;
    logic [W-1:0] m_cos   = '0;
    logic [W-1:0] m_theta = '0;

    // Compare every output against the model, then advance the model
    always @(negedge clk) begin
        logic [N-1:0] e_ack;
        logic         e_busy;
        logic         e_bgn;
        logic         e_err;
        logic [W-1:0] e_cos;
        bit           at_resp;
        if (rst) begin
            m_job   = 1'b0;
            m_last  = N - 1;
            m_theta = '0;
        end
        at_resp = m_job && (cyc == m_resp);
        e_busy  = m_job && (cyc >= m_load) && (cyc <= m_resp);
        e_bgn   = m_job && (cyc == m_load);
        e_ack   = at_resp ? (4'b0001 << m_gidx) : 4'b0000;
        e_err   = at_resp ? m_err : 1'b0;
        e_cos   = at_resp ? m_cos : 16'h0000;
        chk("ack", ack, e_ack);
        chk("err", err, e_err);
        chk("cos_out", cos_out, e_cos);
        chk("busy", busy, e_busy);
        chk("dp_bgn", dp_bgn, e_bgn);
        chk("dp_theta", dp_theta, m_theta);
        if (!rst) begin
            if (m_job) begin
                if (cyc >= m_resp) m_job = 1'b0;
            end else if (req != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int i;
                    i = (m_last + k) % N;
                    if (req[i]) begin
                        m_gidx = i;
                        break;
                    end
                end
                m_last  = m_gidx;
                m_theta = theta_in[m_gidx*W +: W];
                m_load  = cyc + 1;
                m_err   = dp_never || (dp_lat > TMO);
                m_resp  = m_load + (m_err ? TMO : dp_lat) + 1;
                m_cos   = m_err ? 16'h0000 : dp_ret;
                m_job   = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ack(input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(posedge clk);
            #1;
            if (ack != '0) begin
                at = cyc;
                break;
            end
        end
        n_cmp++;
        if (at < 0) begin
            n_bad++;
            $display("FAIL ack_wait: no ack within %0d cycles, required one", max);
        end
    endtask

    // Abort a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] ord [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Directed stimulus
    initial begin
        int g, a, prev, b0;
        rst = 1'b1;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_dp_bgn", dp_bgn, 0);
        chk("rst_dp_theta", dp_theta, 0);
        chk("rst_cos", cos_out, 0);
        rst = 1'b0;
        tick(2);

        // Single requester, latency 17, result 1.0
        theta_in = '0;
        dp_lat   = 17;
        dp_ret   = 16'h4000;
        req      = 4'b0001;
        g        = cyc;
        wait_ack(40, a);
        req = 4'b0000;
        chk("t1_ack", ack, 4'b0001);
        chk("t1_cos", cos_out, 16'h4000);
        chk("t1_err", err, 0);
        chk("t1_latency", a - g, 19);
        chk("t1_bgn_delay", last_bgn - g, 1);
        tick(2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);

        // All four requesting continuously
        theta_in = {16'h3333, 16'h2222, 16'h1111, 16'h0ABC};
        dp_lat   = 5;
        dp_ret   = 16'h1234;
        b0       = n_bgn;
        req      = 4'b1111;
        prev     = -1;
        for (int j = 0; j < 5; j++) begin
            wait_ack(30, a);
            if (j == 4) req = 4'b0000;
            chk("t2_order", ack, ord[j]);
            if (j > 0) chk("t2_gap", a - prev, 8);
            prev = a;
        end
        chk("t2_bgn_count", n_bgn - b0, 5);
        tick(2);

        // Datapath never finishes: timeout, then a normal job
        dp_never = 1'b1;
        req      = 4'b0100;
        wait_ack(60, a);
        req = 4'b0000;
        chk("t3_ack", ack, 4'b0100);
        chk("t3_err", err, 1);
        chk("t3_cos", cos_out, 0);
        chk("t3_tmo_delay", a - last_bgn, TMO + 1);
        dp_never = 1'b0;
        tick(2);
        dp_lat = 3;
        dp_ret = 16'h0777;
        req    = 4'b0100;
        wait_ack(20, a);
        req = 4'b0000;
        chk("t3b_err", err, 0);
        chk("t3b_cos", cos_out, 16'h0777);
        tick(2);

        // Request dropped during RUN still completes; stray dp_fin in IDLE
        dp_lat = 10;
        dp_ret = 16'h1111;
        b0     = n_bgn;
        req    = 4'b0010;
        tick(4);
        req = 4'b0000;
        wait_ack(20, a);
        chk("t4_ack", ack, 4'b0010);
        chk("t4_cos", cos_out, 16'h1111);
        tick(1);
        stray_cyc = cyc + 2;
        tick(6);
        chk("t4_bgn_count", n_bgn - b0, 1);

        // Reset mid-RUN abandons the job; re-grant afterwards
        dp_lat = 20;
        dp_ret = 16'h0555;
        req    = 4'b1000;
        tick(6);
        rst = 1'b1;
        #1;
        chk("t5_busy_async", busy, 0);
        chk("t5_ack_async", ack, 0);
        tick(2);
        rst = 1'b0;
        wait_ack(40, a);
        req = 4'b0000;
        chk("t5_ack", ack, 4'b1000);
        chk("t5_cos", cos_out, 16'h0555);
        tick(2);

        // dp_fin coincides with the timeout limit: completion wins
        dp_lat = TMO;
        dp_ret = 16'h2D41;
        req    = 4'b0001;
        wait_ack(50, a);
        req = 4'b0000;
        chk("t6_ack", ack, 4'b0001);
        chk("t6_err", err, 0);
        chk("t6_cos", cos_out, 16'h2D41);
        chk("t6_delay", a - last_bgn, TMO + 1);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
